// File: rtl/hello_pkg.sv
// Shared types and constants for the HELLO display decoder: character codes,
// segment patterns, rotation table and FSM states.
package hello_pkg;

    typedef enum logic [2:0] {
        BLANK   = 3'd0,
        H       = 3'd1,
        E       = 3'd2,
        L       = 3'd3,
        O       = 3'd4,
        INVALID = 3'd7
    } char_t;

    // Active-low segment patterns, bit 6 = g ... bit 0 = a.
    localparam logic [6:0] SEG_H     = 7'b0001001;
    localparam logic [6:0] SEG_E     = 7'b0000110;
    localparam logic [6:0] SEG_L     = 7'b1000111;
    localparam logic [6:0] SEG_O     = 7'b1000000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    localparam int NUM_ROT = 5;

    // Character codes per rotation, [14:12] = HEX4 ... [2:0] = HEX0.
    localparam logic [NUM_ROT-1:0][14:0] ROT_TABLE = {
        15'b100_001_010_011_011,   // 4: O H E L L
        15'b011_100_001_010_011,   // 3: L O H E L
        15'b011_011_100_001_010,   // 2: L L O H E
        15'b010_011_011_100_001,   // 1: E L L O H
        15'b001_010_011_011_100    // 0: H E L L O
    };

    typedef enum logic {
        S_WAIT = 1'b0,
        S_LOCK = 1'b1
    } state_t;

    function automatic logic [2:0] rot_inc(input logic [2:0] r);
        return (r == 3'd4) ? 3'd0 : r + 3'd1;
    endfunction

    function automatic logic [2:0] rot_dec(input logic [2:0] r);
        return (r == 3'd0) ? 3'd4 : r - 3'd1;
    endfunction

endpackage

// File: rtl/seg7_to_char.sv
// Combinational decode of one active-low 7-segment pattern to a character code.
module seg7_to_char
    import hello_pkg::*;
(
    input  logic [6:0] seg,
    output char_t      ch
);

    always_comb begin
        case (seg)
            SEG_H:     ch = H;
            SEG_E:     ch = E;
            SEG_L:     ch = L;
            SEG_O:     ch = O;
            SEG_BLANK: ch = BLANK;
            default:   ch = INVALID;
        endcase
    end

endmodule

// File: rtl/hex_hello_decoder.sv
// Debounces the five HEX buses, decodes them and reports which HELLO rotation
// is displayed, with change and step-direction pulses on each acceptance.
module hex_hello_decoder
    import hello_pkg::*;
#(
    parameter int STABLE_CYCLES = 4
) (
    input  logic        CLOCK_50,
    input  logic        resetn,
    input  logic [6:0]  HEX4,
    input  logic [6:0]  HEX3,
    input  logic [6:0]  HEX2,
    input  logic [6:0]  HEX1,
    input  logic [6:0]  HEX0,
    output logic [14:0] chars,
    output logic [2:0]  rot_idx,
    output logic        rot_valid,
    output logic        err,
    output logic        new_pulse,
    output logic        step_right,
    output logic        step_left
);

    logic [34:0] din;
    logic [34:0] sample_q;
    logic [34:0] acc_q;
    logic [7:0]  cnt_q;
    logic        has_acc_q;
    logic        prev_valid_q;
    state_t      state_q, state_d;

    char_t       dec [5];
    logic [14:0] dec_chars;
    logic        stable;
    logic        changed;
    logic        accept;
    logic        match;
    logic [2:0]  k;

    logic [14:0] chars_d;
    logic [2:0]  rot_idx_d;
    logic        rot_valid_d, err_d, new_d, right_d, left_d;

    assign din = {HEX4, HEX3, HEX2, HEX1, HEX0};

    for (genvar i = 0; i < 5; i++) begin : g_dec
        seg7_to_char u_dec (
            .seg (sample_q[7*i +: 7]),
            .ch  (dec[i])
        );
    end

    always_comb begin
        for (int i = 0; i < 5; i++) begin
            dec_chars[3*i +: 3] = dec[i];
        end
    end

    // Sample register and run-length counter of identical captures.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others.
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            sample_q <= '1;
            cnt_q    <= 8'd0;
        end else begin
            sample_q <= din;
            if (din == sample_q) begin
                cnt_q <= (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
            end else begin
                cnt_q <= 8'd1;
            end
        end
    end

    assign stable  = (cnt_q >= 8'(STABLE_CYCLES));
    assign changed = (sample_q != acc_q);
    // A changed sample can already be stable while locked only when one capture suffices.
    assign accept  = stable && ((state_q == S_WAIT) || changed);

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            state_q <= S_WAIT;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        // NOTE: every combinationally assigned signal gets a default first so
        // no path through the block can infer a latch.
        state_d = state_q;
        case (state_q)
            S_WAIT:  if (stable) state_d = S_LOCK;
            S_LOCK:  if (changed && !stable) state_d = S_WAIT;
            default: state_d = S_WAIT;
        endcase
    end

    always_comb begin
        match = 1'b0;
        k     = 3'd0;
        for (int r = 0; r < NUM_ROT; r++) begin
            if (dec_chars == ROT_TABLE[3'(r)]) begin
                match = 1'b1;
                k     = 3'(r);
            end
        end

        chars_d     = chars;
        rot_idx_d   = rot_idx;
        rot_valid_d = rot_valid;
        err_d       = err;
        new_d       = 1'b0;
        right_d     = 1'b0;
        left_d      = 1'b0;
        if (accept) begin
            chars_d = dec_chars;
            new_d   = !has_acc_q || changed;
            if (match) begin
                rot_idx_d   = k;
                rot_valid_d = 1'b1;
                err_d       = 1'b0;
                // rot_idx still holds the previous valid rotation here.
                right_d     = prev_valid_q && (k == rot_inc(rot_idx));
                left_d      = prev_valid_q && (k == rot_dec(rot_idx));
            end else begin
                rot_valid_d = 1'b0;
                err_d       = 1'b1;
            end
        end
    end

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            acc_q        <= '1;
            has_acc_q    <= 1'b0;
            prev_valid_q <= 1'b0;
            chars        <= '0;
            rot_idx      <= 3'd0;
            rot_valid    <= 1'b0;
            err          <= 1'b0;
            new_pulse    <= 1'b0;
            step_right   <= 1'b0;
            step_left    <= 1'b0;
        end else begin
            if (accept) begin
                acc_q        <= sample_q;
                has_acc_q    <= 1'b1;
                prev_valid_q <= prev_valid_q | match;
            end
            chars      <= chars_d;
            rot_idx    <= rot_idx_d;
            rot_valid  <= rot_valid_d;
            err        <= err_d;
            new_pulse  <= new_d;
            step_right <= right_d;
            step_left  <= left_d;
        end
    end

endmodule

// File: doc/hex_hello_decoder.md
# hex_hello_decoder

Receive-side counterpart of the HELLO scroller: samples the five active-low 7-segment buses HEX4..HEX0, filters glitches, decodes each digit to a character code and identifies which rotation of "HELLO" is on display. It publishes the rotation index and per-step direction pulses, so a bench or a downstream checker can verify the scroller's output without reading raw segment patterns.

## Interface
- STABLE_CYCLES, default 4: consecutive identical samples required before a pattern is accepted; legal range 1..255.
- CLOCK_50  in  1  system clock; all state on rising edge.
- resetn  in  1  asynchronous, active-low reset.
- HEX4..HEX0  in  7 each  segment patterns, bit 6 = g … bit 0 = a, active-low (0 = lit).
- chars  out  15  accepted character codes, [14:12]=HEX4 … [2:0]=HEX0.
- rot_idx  out  3  rotation index 0..4 of last accepted valid pattern.
- rot_valid  out  1  last accepted pattern is a legal HELLO rotation.
- err  out  1  last accepted pattern is not a legal rotation.
- new_pulse  out  1  one-cycle pulse: accepted pattern differs from the previously accepted one.
- step_right  out  1  one-cycle pulse: rotation advanced by +1 mod 5.
- step_left  out  1  one-cycle pulse: rotation moved by −1 mod 5.

## Operation
- Per-digit decode: 0001001→H(1), 0000110→E(2), 1000111→L(3), 1000000→O(4), 1111111→BLANK(0), any other→INVALID(7).
- Rotation table (HEX4..HEX0): 0=H E L L O, 1=E L L O H, 2=L L O H E, 3=L O H E L, 4=O H E L L.
- Inputs captured every cycle into a 35-bit sample register; a saturating 8-bit counter tracks consecutive identical samples.
- FSM: S_WAIT (pattern unsettled) and S_LOCK (pattern accepted).
  - S_WAIT→S_LOCK when the sample has been identical for STABLE_CYCLES captures; outputs published on that edge.
  - S_LOCK→S_WAIT on any sample change; outputs hold their accepted values while in S_WAIT.
  - S_LOCK with unchanged input: stay, no pulses.
- On acceptance: chars updated; if pattern matches rotation k: rot_idx=k, rot_valid=1, err=0; else rot_valid=0, err=1, rot_idx holds its last valid value.
- new_pulse fires on acceptance iff the 35-bit pattern differs from the previously accepted pattern (first acceptance after reset always fires).
- Step pulses only when the new pattern is valid and a previous valid rotation p exists since reset: step_right if k==(p+1) mod 5, step_left if k==(p+4) mod 5, neither otherwise (jump or k==p after an invalid interlude). Previous valid rotation survives intervening invalid patterns.
- step_right and step_left are never asserted together; both imply new_pulse.

## Timing
- Reset values: chars=0 (all BLANK), rot_idx=0, rot_valid=0, err=0, all pulses 0, state S_WAIT, sample register all ones, counter 0, "previous valid exists" flag 0.
- Latency: input stable from edge n (first capture) → outputs and pulses registered at edge n+STABLE_CYCLES−1+1, i.e. visible after edge n+STABLE_CYCLES.
- A change arriving on the acceptance edge itself is captured normally and restarts the count; acceptance of the old pattern still completes.
- Glitch shorter than STABLE_CYCLES: no output change, no pulses.
- Reset asserted mid-count or in S_LOCK: all state returns to reset values immediately; first post-reset acceptance treated as first ever.
- STABLE_CYCLES=1: acceptance one edge after capture, every new distinct sample accepted.

## Structure
- Package hello_pkg: char_t enum (BLANK,H,E,L,O,INVALID), segment-pattern constants, rotation table constant, state_t enum.
- Sub-module seg7_to_char: combinational 7-bit→char_t decoder, instantiated five times.

## Test plan
- Reset, inputs all 1111111 for 10 cycles → chars=0, err=1 after 4 cycles, new_pulse once, rot_valid=0.
- Apply rotation 0 then 1, each held 8 cycles → rot_idx 0 then 1, rot_valid=1, step_right on second acceptance only.
- Rotation 4 then 0 → step_right (wrap); rotation 0 then 4 → step_left.
- Rotation 2, 3-cycle glitch to rotation 3, back to 2 → no output change, no pulses.
- Rotation 1, invalid pattern (HEX0=0000000), rotation 2 → err=1 then rot_valid=1, rot_idx=2, step_right on final acceptance.
- Reset asserted during count of rotation 3 → outputs to reset values; after release, rotation 3 accepted with new_pulse, no step pulse.
